// File: rtl/result_uart_pkg.sv
// rtl/result_uart_pkg.sv - shared types and constants for the result UART transmitter
package result_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_START_BIT     = 1'b0;
  localparam logic UART_STOP_BIT      = 1'b1;
  localparam int   UART_BITS_PER_BYTE = 8;
  localparam int   RESULT_WIDTH       = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - captures result words on ready rising edges and sends them as two 8N1 bytes
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [RESULT_WIDTH-1:0]       data_in,
  input  logic                          data_ready,
  input  logic                          clr_overflow,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e             state_q, state_d;
  logic [CW-1:0]           baud_q, baud_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic                    byte_sel_q, byte_sel_d;
  logic [7:0]              shift_q, shift_d;
  logic [RESULT_WIDTH-1:0] hold_q, hold_d;
  logic                    txd_q, txd_d;
  logic                    ready_prev_q;
  logic                    overflow_q, overflow_d;
  logic                    busy_q;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [RESULT_WIDTH-1:0] fifo_rdata;
  logic                    baud_done, load_word;

  assign fifo_push = data_ready & ~ready_prev_q;
  assign baud_done = (baud_q == CW'(CLKS_PER_BIT-1));

  sync_fifo #(.WIDTH(RESULT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (data_in),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;
    load_word  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        txd_d  = UART_STOP_BIT;
        if (!fifo_empty) load_word = 1'b1;
      end
      ST_START: begin
        if (baud_done) begin
          state_d   = ST_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'(UART_BITS_PER_BYTE-1)) begin
            state_d = ST_STOP;
            txd_d   = UART_STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            shift_d    = hold_q[7:0];
            txd_d      = UART_START_BIT;
            state_d    = ST_START;
          end else if (!fifo_empty) begin
            load_word = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop straight into the start bit so consecutive words leave no idle gap.
    if (load_word) begin
      fifo_pop   = 1'b1;
      hold_d     = fifo_rdata;
      byte_sel_d = 1'b0;
      shift_d    = fifo_rdata[15:8];
      txd_d      = UART_START_BIT;
      state_d    = ST_START;
      baud_d     = '0;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      byte_sel_q   <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      txd_q        <= UART_STOP_BIT;
      ready_prev_q <= 1'b1;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      byte_sel_q   <= byte_sel_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      txd_q        <= txd_d;
      ready_prev_q <= data_ready;
      overflow_q   <= overflow_d;
      busy_q       <= (state_d != ST_IDLE) | (fifo_count != '0);
    end
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - scoreboard bench decoding the UART line against queued result words
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        uart_txd, busy, overflow;
  logic [2:0]  fifo_count;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .clr_overflow (clr_overflow),
    .uart_txd     (uart_txd),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int          chk_total = 0;
  int          chk_pass  = 0;
  logic [15:0] exp_q[$];
  int          wstart_q[$];

  task automatic check(input string name, input int act, input int exp);
    chk_total++;
    if (act == exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  bit         mon_en = 1'b1;
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_cnt, m_start;
  logic [7:0] m_byte;
  bit         hi_pending = 1'b0;
  logic [7:0] hi_byte;
  int         hi_start;
  int         max_count = 0;

  // Line decoder: cycle 0 of a frame is the first sample with the start bit low.
  always @(negedge clk) begin
    cyc++;
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    if (!mon_en || !reset_n) begin
      m_active   = 1'b0;
      hi_pending = 1'b0;
    end else if (!m_active) begin
      if (uart_txd == 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_start  = cyc;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0)
        m_byte[(m_cnt - 6) / 4] = uart_txd;
      if (m_cnt == 38) begin
        m_active = 1'b0;
        check("stop_bit", int'(uart_txd), 1);
        if (!hi_pending) begin
          hi_byte    = m_byte;
          hi_start   = m_start;
          hi_pending = 1'b1;
        end else begin
          hi_pending = 1'b0;
          check("byte_gap", m_start - hi_start, 40);
          check("word_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("word", int'({hi_byte, m_byte}), int'(exp_q.pop_front()));
          wstart_q.push_back(hi_start);
        end
      end
    end
  end

  task automatic pulse(input logic [15:0] w, input bit accept);
    @(negedge clk);
    data_in    = w;
    data_ready = 1'b1;
    if (accept) exp_q.push_back(w);
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || fifo_count != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(n < limit), 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n0;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_txd", int'(uart_txd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word 0xA55A: latency, busy window and peak occupancy.
    @(negedge clk);
    data_in    = 16'hA55A;
    data_ready = 1'b1;
    exp_q.push_back(16'hA55A);
    max_count  = 0;
    @(negedge clk);
    data_ready = 1'b0;
    check("cap_count", int'(fifo_count), 1);
    check("txd_before_start", int'(uart_txd), 1);
    @(negedge clk);
    check("txd_start_latency", int'(uart_txd), 0);
    check("count_after_pop", int'(fifo_count), 0);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 80);
    check("txd_idle_after", int'(uart_txd), 1);
    check("peak_count", max_count, 1);
    repeat (4) @(negedge clk);

    // Level held high with changing data: one capture only.
    n0 = wstart_q.size();
    max_count = 0;
    @(negedge clk);
    data_in    = 16'h1234;
    data_ready = 1'b1;
    exp_q.push_back(16'h1234);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      data_in = data_in + 16'h0101;
    end
    data_ready = 1'b0;
    check("held_peak", max_count, 1);
    wait_idle(400);
    check("held_one_word", wstart_q.size() - n0, 1);

    // Six pulses into a depth-4 FIFO: one in hold, four queued, last dropped.
    n0 = wstart_q.size();
    for (int i = 1; i <= 6; i++) pulse(16'(i), i <= 5);
    check("fill_count", int'(fifo_count), 4);
    check("overflow_set", int'(overflow), 1);
    @(negedge clk);
    data_in      = 16'h0007;
    data_ready   = 1'b1;
    clr_overflow = 1'b1;
    @(negedge clk);
    data_ready   = 1'b0;
    clr_overflow = 1'b0;
    check("overflow_set_wins", int'(overflow), 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("overflow_cleared", int'(overflow), 0);
    wait_idle(1000);
    check("burst_words", wstart_q.size() - n0, 5);
    for (int i = 1; i < 5; i++)
      if (n0 + i < wstart_q.size())
        check("burst_back_to_back", wstart_q[n0 + i] - wstart_q[n0 + i - 1], 80);

    // Full FIFO with a push on the STOP->START pop edge.
    pulse(16'h0F01, 1'b1);
    for (int i = 2; i <= 5; i++) pulse(16'h0F00 | 16'(i), 1'b1);
    check("full_before", int'(fifo_count), 4);
    repeat (71) @(negedge clk);
    pulse(16'h0F06, 1'b1);
    check("full_pushpop_count", int'(fifo_count), 4);
    check("full_pushpop_overflow", int'(overflow), 0);
    check("full_pushpop_restart", int'(uart_txd), 0);
    wait_idle(1000);
    check("all_words_sent", exp_q.size(), 0);

    // Reset in the middle of the high byte with two words queued.
    pulse(16'hE001, 1'b0);
    pulse(16'hE002, 1'b0);
    pulse(16'hE003, 1'b0);
    check("queued_before_reset", int'(fifo_count), 2);
    repeat (10) @(negedge clk);
    mon_en     = 1'b0;
    reset_n    = 1'b0;
    data_ready = 1'b1;
    #1;
    check("async_rst_txd", int'(uart_txd), 1);
    check("async_rst_count", int'(fifo_count), 0);
    check("async_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || fifo_count != 0) ok = 1'b0;
    end
    check("no_capture_after_reset", int'(ok), 1);
    data_ready = 1'b0;

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
